// File: rtl/tc_sequencer.sv
// tc_sequencer: training-case sequencer for the DNN trainer.
// Steps a training-case address once per block cycle across TC cases and
// EPOCHS epochs, reads the class label for that case, and expands it to a
// zero-padded one-hot ideal output that is sliced per clock by cycle_index.
// Label contents come from the LABELS parameter (TC packed LW-bit class indices,
// entry i at bits [i*LW +: LW]).
// Optional feature macro: TC_SHUFFLE_EN (strided addressing with a per-epoch
// rotating base; STRIDE must be coprime with TC and smaller than TC).
module tc_sequencer #(
  parameter  int NOUT     = 10,
  parameter  int NOUT_PAD = 32,
  parameter  int SLICE    = 1,
  parameter  int TC       = 12544,
  parameter  int EPOCHS   = 10,
  parameter  int STRIDE   = 5,
  localparam int AW       = $clog2(TC),
  localparam int LW       = $clog2(NOUT_PAD),
  localparam int FEED     = NOUT_PAD / SLICE,
  localparam int CPC      = FEED + 2,
  localparam int CIW      = $clog2(CPC),
  localparam int EW       = $clog2(EPOCHS + 1),
  parameter  logic [TC*LW-1:0] LABELS = '0
) (
  input  logic                cycle_clk,
  input  logic                reset,
  input  logic                en,
  input  logic [CIW-1:0]      cycle_index,
  output logic [AW-1:0]       tc_addr,
  output logic [EW-1:0]       epoch,
  output logic                tc_valid,
  output logic                epoch_done,
  output logic                train_done,
  output logic                label_err,
  output logic [NOUT_PAD-1:0] ans_onehot,
  output logic [SLICE-1:0]    ans_slice
);

  localparam int FW = (FEED > 1) ? $clog2(FEED) : 1;
  localparam logic [AW-1:0] LAST_ADDR  = AW'(TC - 1);
  localparam logic [EW-1:0] LAST_EPOCH = EW'(EPOCHS - 1);
  localparam logic [EW-1:0] ALL_EPOCHS = EW'(EPOCHS);
  localparam logic [LW:0]   NOUT_W     = (LW + 1)'(NOUT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [EW-1:0]   epoch_q, epoch_d;
  logic [LW-1:0]   label_q, label_d;
  logic            pulse_q, pulse_d;
  logic            err_q, err_d;
  logic            last_case;
  logic [AW-1:0]   step_addr;
  logic [AW-1:0]   wrap_addr;

  // Label ROM read, zero latency relative to the address it is given.
  function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
    return LABELS[int'(a)*LW +: LW];
  endfunction

`ifdef TC_SHUFFLE_EN
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   stride_sum;

  // Strided successor (single compare/subtract) and next epoch's base.
  always_comb begin
    stride_sum = {1'b0, addr_q} + (AW + 1)'(STRIDE);
    if (stride_sum >= (AW + 1)'(TC)) stride_sum = stride_sum - (AW + 1)'(TC);
    step_addr  = stride_sum[AW-1:0];
    wrap_addr  = (base_q == LAST_ADDR) ? '0 : base_q + AW'(1);
    last_case  = (cnt_q == LAST_ADDR);
  end

  // Case counter and epoch base advance together with the address.
  always_comb begin
    cnt_d  = cnt_q;
    base_d = base_q;
    if (state_q == S_RUN && en && !(last_case && epoch_q == LAST_EPOCH)) begin
      if (last_case) begin
        cnt_d  = '0;
        base_d = wrap_addr;
      end else begin
        cnt_d  = cnt_q + AW'(1);
      end
    end
  end

  // Shuffle bookkeeping registers.
  always_ff @(posedge cycle_clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      base_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
    end
  end
`else
  localparam int unused_stride = STRIDE;

  // Sequential successor; the wrap is detected on the address itself.
  always_comb begin
    step_addr = addr_q + AW'(1);
    wrap_addr = '0;
    last_case = (addr_q == LAST_ADDR);
  end
`endif

  // Next-state logic: IDLE -> RUN on en, RUN steps cases/epochs, DONE is terminal.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    epoch_d = epoch_q;
    label_d = label_q;
    pulse_d = 1'b0;
    err_d   = err_q | ({1'b0, label_q} >= NOUT_W);
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          label_d = mem_rd('0);
        end
      end
      S_RUN: begin
        if (en) begin
          if (last_case) begin
            if (epoch_q == LAST_EPOCH) begin
              state_d = S_DONE;
              epoch_d = ALL_EPOCHS;
            end else begin
              epoch_d = epoch_q + EW'(1);
              pulse_d = 1'b1;
              addr_d  = wrap_addr;
            end
          end else begin
            addr_d = step_addr;
          end
          label_d = mem_rd(addr_d);
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge cycle_clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      epoch_q <= '0;
      label_q <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      epoch_q <= epoch_d;
      label_q <= label_d;
      pulse_q <= pulse_d;
      err_q   <= err_d;
    end
  end

  assign tc_addr    = addr_q;
  assign epoch      = epoch_q;
  assign tc_valid   = (state_q == S_RUN);
  assign train_done = (state_q == S_DONE);
  assign epoch_done = pulse_q;
  assign label_err  = err_q;

  // One-hot expansion of the current label; out-of-range labels and idle/done give zero.
  always_comb begin
    ans_onehot = '0;
    for (int i = 0; i < NOUT_PAD; i++) begin
      ans_onehot[i] = tc_valid && (i < NOUT) && (int'(label_q) == i);
    end
  end

  logic [FW-1:0] sel;
  logic          unused_ci;

  // Slice select: two clocks of pipeline lead, wrapping modulo FEED.
  always_comb begin
    sel       = cycle_index[FW-1:0] - FW'(2);
    ans_slice = ans_onehot[int'(sel)*SLICE +: SLICE];
  end

  assign unused_ci = ^cycle_index[CIW-1:FW];

endmodule

// File: tb/tb_tc_sequencer.sv
// tb_tc_sequencer: self-checking bench for tc_sequencer (TC=8, EPOCHS=2,
// NOUT=10, NOUT_PAD=16, SLICE=1, labels 3,0,9,12,1,2,5,7). Works with or
// without TC_SHUFFLE_EN (STRIDE=3 for the shuffled order).
module tb_tc_sequencer;

  localparam int TC       = 8;
  localparam int EPOCHS   = 2;
  localparam int NOUT     = 10;
  localparam int NOUT_PAD = 16;
  localparam int SLICE    = 1;
  localparam int STRIDE   = 3;
  localparam int FEED     = NOUT_PAD / SLICE;
  localparam logic [TC*4-1:0] LABELS = 32'h7521_c903;

  logic        cycle_clk;
  logic        reset;
  logic        en;
  logic [4:0]  cycle_index;
  logic [2:0]  tc_addr;
  logic [1:0]  epoch;
  logic        tc_valid;
  logic        epoch_done;
  logic        train_done;
  logic        label_err;
  logic [15:0] ans_onehot;
  logic [0:0]  ans_slice;

  tc_sequencer #(
    .NOUT(NOUT), .NOUT_PAD(NOUT_PAD), .SLICE(SLICE), .TC(TC),
    .EPOCHS(EPOCHS), .STRIDE(STRIDE), .LABELS(LABELS)
  ) dut (
    .cycle_clk(cycle_clk), .reset(reset), .en(en), .cycle_index(cycle_index),
    .tc_addr(tc_addr), .epoch(epoch), .tc_valid(tc_valid), .epoch_done(epoch_done),
    .train_done(train_done), .label_err(label_err), .ans_onehot(ans_onehot),
    .ans_slice(ans_slice)
  );

  initial begin
    cycle_clk = 1'b0;
    forever #5 cycle_clk = ~cycle_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: case k of epoch e is at address k (sequential) or
  // (e + k*STRIDE) mod TC (shuffled, base advances by one per epoch).
  int lbl[TC] = '{3, 0, 9, 12, 1, 2, 5, 7};
  int m_mode;   // 0 idle, 1 running, 2 done
  int m_epoch;
  int m_case;
  int m_addr;
  bit m_pulse;
  bit m_err;

  function automatic int addr_of(input int e, input int k);
`ifdef TC_SHUFFLE_EN
    return (e + k * STRIDE) % TC;
`else
    return k;
`endif
  endfunction

  task automatic model_edge(input bit r, input bit e_in);
    if (!r) begin
      m_mode = 0; m_epoch = 0; m_case = 0; m_addr = 0; m_pulse = 0; m_err = 0;
      return;
    end
    if (m_mode != 0 && lbl[m_addr] >= NOUT) m_err = 1;
    m_pulse = 0;
    if (m_mode == 0) begin
      if (e_in) m_mode = 1;
    end else if (m_mode == 1 && e_in) begin
      if (m_case == TC - 1) begin
        if (m_epoch == EPOCHS - 1) begin
          m_mode  = 2;
          m_epoch = EPOCHS;
        end else begin
          m_epoch++;
          m_case  = 0;
          m_pulse = 1;
        end
      end else begin
        m_case++;
      end
      if (m_mode == 1) m_addr = addr_of(m_epoch, m_case);
    end
  endtask

  task automatic compare_all(input int ci);
    logic [15:0] eo;
    int sel;
    eo = '0;
    if (m_mode == 1 && lbl[m_addr] < NOUT) eo[lbl[m_addr]] = 1'b1;
    sel = ((ci - 2) % FEED + FEED) % FEED;
    check("tc_addr",    tc_addr,    m_addr);
    check("epoch",      epoch,      m_epoch);
    check("tc_valid",   tc_valid,   m_mode == 1);
    check("train_done", train_done, m_mode == 2);
    check("epoch_done", epoch_done, m_pulse);
    check("label_err",  label_err,  m_err);
    check("ans_onehot", ans_onehot, eo);
    check("ans_slice",  ans_slice,  eo[sel]);
  endtask

  // Drive one block cycle, then compare every output against the model.
  task automatic step(input bit r, input bit e_in, input int ci);
    reset       = r;
    en          = e_in;
    cycle_index = 5'(ci);
    @(posedge cycle_clk);
    #1;
    model_edge(r, e_in);
    compare_all(ci);
  endtask

  // Advance with en=1 until the model says we are at (addr, epoch); bounded.
  task automatic run_until(input int a, input int e);
    int n;
    n = 0;
    while (!(m_mode == 1 && m_addr == a && m_epoch == e) && n < 40) begin
      step(1'b1, 1'b1, 5);
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_until: addr %0d epoch %0d not reached in 40 cycles", a, e);
    end
  endtask

  typedef struct {
    int         ci;
    logic [0:0] exp_slice;
  } slice_vec_t;

  slice_vec_t vecs[18];
  int         exp_order[16];
  int         pulses;

  initial begin
    // Cycle-index sweep at label 3: only sel 3 (cycle_index 5) is hot.
    for (int i = 0; i < 18; i++) begin
      vecs[i].ci        = i;
      vecs[i].exp_slice = (i == 5) ? 1'b1 : 1'b0;
    end
`ifdef TC_SHUFFLE_EN
    exp_order = '{0, 3, 6, 1, 4, 7, 2, 5, 1, 4, 7, 2, 5, 0, 3, 6};
`else
    exp_order = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};
`endif

    reset = 1'b0; en = 1'b0; cycle_index = '0;
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 0);

    // Full run: two epochs, one epoch_done pulse, train_done holds with en high.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, i % 18);
      if (epoch_done) pulses++;
    end
    check("epoch_done_count", pulses, 1);
    check("done_level", train_done, 1);
    check("done_epoch", epoch, EPOCHS);

    // Address order over both epochs, including the enable cycle into RUN.
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    check("order_0", tc_addr, exp_order[0]);
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 1'b1, 5);
      check("order", tc_addr, exp_order[i]);
    end

    // Slice sweep at tc_addr 0 (label 3), holding with en low.
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 0);
    for (int i = 0; i < 18; i++) begin
      cycle_index = 5'(vecs[i].ci);
      en          = 1'b0;
      #1;
      check("sweep_slice", ans_slice, vecs[i].exp_slice);
      check("sweep_onehot", ans_onehot, 16'h0008);
    end

    // Out-of-range label 12 at address 3: zero one-hot, sticky label_err.
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    run_until(3, 0);
    check("bad_label_onehot", ans_onehot, 0);
    check("err_before", label_err, 0);
    step(1'b1, 1'b1, 5);
    check("err_set", label_err, 1);

    // Pause at address 5: everything holds, then resumes at the successor.
    run_until(5, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 5);
      check("pause_addr", tc_addr, 5);
    end
    step(1'b1, 1'b1, 5);
`ifdef TC_SHUFFLE_EN
    check("resume_addr", tc_addr, 1);
`else
    check("resume_addr", tc_addr, 6);
`endif
    check("err_sticky", label_err, 1);

    // Reset mid-run at epoch 1 address 4, then restart from zero.
    run_until(4, 1);
    step(1'b0, 1'b1, 5);
    check("rst_valid", tc_valid, 0);
    check("rst_err", label_err, 0);
    step(1'b1, 1'b1, 5);
    check("restart_addr", tc_addr, 0);
    check("restart_epoch", epoch, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 17)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
